// File: rtl/imm_extend_pipe_if.sv
// imm_extend_pipe_if
//   Groups the decode-side and ALU-side handshake signals of imm_extend_pipe.
//   Input side:  in_valid / in_ready carry imm (IN_W bits) and mode (2 bits).
//   Output side: out_valid / out_ready carry out_data (OUT_W bits) and out_mode.
//   modport slave  : the extension unit itself.
//   modport master : the environment (decode stage, ALU mux or a testbench).
interface imm_extend_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  imm;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [1:0]       out_mode;

  modport master (
    output in_valid, imm, mode, out_ready,
    input  in_ready, out_valid, out_data, out_mode
  );

  modport slave (
    input  in_valid, imm, mode, out_ready,
    output in_ready, out_valid, out_data, out_mode
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Pipelined immediate extender placed between instruction decode and the
//   ALU operand mux. The extension is computed on the input side, then the
//   result is held in an output register (OR) backed by a one-entry skid
//   register (SK) so that in_ready can be a plain register.
//   Modes: 00 sign, 01 zero, 10 upper (imm in the top bits),
//          11 branch (sign-extended then shifted left by 2).
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-high; drops every held result
//   bus   : imm_extend_pipe_if.slave (input and output handshakes)
// Parameters:
//   IN_W  : immediate width, at least 2
//   OUT_W : operand width, greater than IN_W + 1
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  imm_extend_pipe_if.slave bus
);
  localparam int EXT_W = OUT_W - IN_W;

  // The state is the pair of valid bits: EMPTY (none), ONE (OR), FULL (OR+SK).
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t           state_reg, state_next;
  logic             in_ready_reg, in_ready_next;
  logic [OUT_W-1:0] or_data_reg, or_data_next;
  logic [1:0]       or_mode_reg, or_mode_next;
  logic [OUT_W-1:0] sk_data_reg, sk_data_next;
  logic [1:0]       sk_mode_reg, sk_mode_next;

  logic [OUT_W-1:0] sign_ext, zero_ext, upper_ext, branch_ext, ext_data;
  logic             in_xfer, out_xfer;

  // Bit-wise construction of the four candidate extensions.
  genvar gi;
  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_ext
      if (gi < IN_W) begin : g_low
        assign sign_ext[gi] = bus.imm[gi];
        assign zero_ext[gi] = bus.imm[gi];
      end else begin : g_high
        assign sign_ext[gi] = bus.imm[IN_W-1];
        assign zero_ext[gi] = 1'b0;
      end
      if (gi < EXT_W) begin : g_up_zero
        assign upper_ext[gi] = 1'b0;
      end else begin : g_up_imm
        assign upper_ext[gi] = bus.imm[gi-EXT_W];
      end
      // Branch offset: sign result moved up two places, top two bits lost.
      if (gi < 2) begin : g_br_zero
        assign branch_ext[gi] = 1'b0;
      end else begin : g_br_sign
        assign branch_ext[gi] = sign_ext[gi-2];
      end
    end
  endgenerate

  always_comb begin
    ext_data = sign_ext;
    case (bus.mode)
      2'b00:   ext_data = sign_ext;
      2'b01:   ext_data = zero_ext;
      2'b10:   ext_data = upper_ext;
      default: ext_data = branch_ext;
    endcase
  end

  // State register; reset wins over any transfer presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= EMPTY;
      in_ready_reg <= 1'b1;
      or_data_reg  <= '0;
      or_mode_reg  <= 2'b00;
      sk_data_reg  <= '0;
      sk_mode_reg  <= 2'b00;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= in_ready_next;
      or_data_reg  <= or_data_next;
      or_mode_reg  <= or_mode_next;
      sk_data_reg  <= sk_data_next;
      sk_mode_reg  <= sk_mode_next;
    end
  end

  // Next-state and storage steering.
  always_comb begin
    state_next   = state_reg;
    or_data_next = or_data_reg;
    or_mode_next = or_mode_reg;
    sk_data_next = sk_data_reg;
    sk_mode_next = sk_mode_reg;
    in_xfer      = bus.in_valid && in_ready_reg;
    out_xfer     = (state_reg != EMPTY) && bus.out_ready;

    case (state_reg)
      EMPTY: begin
        if (in_xfer) begin
          state_next   = ONE;
          or_data_next = ext_data;
          or_mode_next = bus.mode;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          or_data_next = ext_data;
          or_mode_next = bus.mode;
        end else if (in_xfer) begin
          // OR is stalled, so the new result parks in the skid register.
          state_next   = FULL;
          sk_data_next = ext_data;
          sk_mode_next = bus.mode;
        end else if (out_xfer) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain path can fire.
        if (out_xfer) begin
          state_next   = ONE;
          or_data_next = sk_data_reg;
          or_mode_next = sk_mode_reg;
          sk_data_next = '0;
          sk_mode_next = 2'b00;
        end
      end
      default: state_next = EMPTY;
    endcase

    // Registered ready: looks only at the next state, never at out_ready directly.
    in_ready_next = (state_next != FULL);
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = (state_reg != EMPTY);
  assign bus.out_data  = or_data_reg;
  assign bus.out_mode  = or_mode_reg;
endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) bus_a ();
  imm_extend_pipe_if #(.IN_W(8),  .OUT_W(16)) bus_b ();

  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave)
  );
  imm_extend_pipe #(.IN_W(8), .OUT_W(16)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );

  typedef struct {
    logic [31:0] d;
    logic [1:0]  m;
  } item_t;

  // Reference extension from plain integer arithmetic.
  function automatic longint model_f(int in_w, int out_w, longint imm, logic [1:0] m);
    longint mask = (longint'(1) << out_w) - 1;
    longint sv   = imm;
    if (imm >= (longint'(1) << (in_w - 1))) sv = imm - (longint'(1) << in_w);
    case (m)
      2'b00:   return sv & mask;
      2'b01:   return imm;
      2'b10:   return (imm * (longint'(1) << (out_w - in_w))) & mask;
      default: return (sv * 4) & mask;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(logic v, logic [15:0] i, logic [1:0] m, logic r);
    bus_a.in_valid  = v;
    bus_a.imm       = i;
    bus_a.mode      = m;
    bus_a.out_ready = r;
  endtask

  task automatic test_reset();
    drive_a(1'b0, 16'h0, 2'b00, 1'b0);
    bus_b.in_valid = 1'b0; bus_b.imm = 8'h0; bus_b.mode = 2'b00; bus_b.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1 ||
        bus_a.out_data !== 32'h0 || bus_a.out_mode !== 2'b00) begin
      failures++;
      $display("FAIL reset_a: got v=%b r=%b d=%h m=%b expected v=0 r=1 d=00000000 m=00",
               bus_a.out_valid, bus_a.in_ready, bus_a.out_data, bus_a.out_mode);
    end
    checks++;
    if (bus_b.out_valid !== 1'b0 || bus_b.in_ready !== 1'b1 || bus_b.out_data !== 16'h0) begin
      failures++;
      $display("FAIL reset_b: got v=%b r=%b d=%h expected v=0 r=1 d=0000",
               bus_b.out_valid, bus_b.in_ready, bus_b.out_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] imms  [5] = '{16'hAAAA, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h5555};
    logic [1:0]  modes [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    logic [31:0] exps  [5] = '{32'hFFFFAAAA, 32'h0000AAAA, 32'h55550000, 32'hFFFFFFFC, 32'h00005555};
    for (int k = 0; k < 5; k++) begin
      drive_a(1'b1, imms[k], modes[k], 1'b1);
      checks++;
      if (bus_a.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_ready[%0d]: got %b expected 1", k, bus_a.in_ready);
      end
      step();
      checks++;
      if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== exps[k] || bus_a.out_mode !== modes[k]) begin
        failures++;
        $display("FAIL stream_out[%0d]: got v=%b d=%h m=%b expected v=1 d=%h m=%b",
                 k, bus_a.out_valid, bus_a.out_data, bus_a.out_mode, exps[k], modes[k]);
      end
    end
    drive_a(1'b0, 16'h0, 2'b00, 1'b1);
    step();
    checks++;
    if (bus_a.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_empty: got out_valid=%b expected 0", bus_a.out_valid);
    end
  endtask

  task automatic test_backpressure();
    drive_a(1'b1, 16'h0001, 2'b00, 1'b0);
    step();
    drive_a(1'b1, 16'h0002, 2'b00, 1'b0);
    step();
    checks++;
    if (bus_a.in_ready !== 1'b0 || bus_a.out_data !== 32'h1) begin
      failures++;
      $display("FAIL bp_full: got r=%b d=%h expected r=0 d=00000001", bus_a.in_ready, bus_a.out_data);
    end
    drive_a(1'b1, 16'h0003, 2'b00, 1'b0);
    step();
    checks++;
    if (bus_a.in_ready !== 1'b0 || bus_a.out_data !== 32'h1 || bus_a.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_hold: got v=%b r=%b d=%h expected v=1 r=0 d=00000001",
               bus_a.out_valid, bus_a.in_ready, bus_a.out_data);
    end
    // 0x1 leaves at this edge; 0x3 is still refused because in_ready was low.
    drive_a(1'b1, 16'h0003, 2'b00, 1'b1);
    step();
    checks++;
    if (bus_a.out_data !== 32'h2 || bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_drain1: got v=%b r=%b d=%h expected v=1 r=1 d=00000002",
               bus_a.out_valid, bus_a.in_ready, bus_a.out_data);
    end
    step();
    checks++;
    if (bus_a.out_data !== 32'h3 || bus_a.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_drain2: got v=%b d=%h expected v=1 d=00000003", bus_a.out_valid, bus_a.out_data);
    end
    drive_a(1'b0, 16'h0, 2'b00, 1'b1);
    step();
    checks++;
    if (bus_a.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty: got out_valid=%b expected 0", bus_a.out_valid);
    end
  endtask

  task automatic test_drain_refill();
    drive_a(1'b1, 16'h0011, 2'b01, 1'b0);
    step();
    drive_a(1'b1, 16'h0022, 2'b10, 1'b0);
    step();
    // FULL: one cycle of out_ready while a new input is offered.
    drive_a(1'b1, 16'h8033, 2'b00, 1'b1);
    step();
    checks++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 32'h00220000 ||
        bus_a.out_mode !== 2'b10 || bus_a.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL refill_one: got v=%b r=%b d=%h m=%b expected v=1 r=1 d=00220000 m=10",
               bus_a.out_valid, bus_a.in_ready, bus_a.out_data, bus_a.out_mode);
    end
    drive_a(1'b1, 16'h8033, 2'b00, 1'b0);
    step();
    checks++;
    if (bus_a.in_ready !== 1'b0 || bus_a.out_data !== 32'h00220000) begin
      failures++;
      $display("FAIL refill_take: got r=%b d=%h expected r=0 d=00220000", bus_a.in_ready, bus_a.out_data);
    end
    drive_a(1'b0, 16'h0, 2'b00, 1'b1);
    step();
    checks++;
    if (bus_a.out_data !== 32'hFFFF8033 || bus_a.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL refill_out: got v=%b d=%h expected v=1 d=ffff8033", bus_a.out_valid, bus_a.out_data);
    end
    step();
    checks++;
    if (bus_a.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL refill_empty: got out_valid=%b expected 0", bus_a.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    drive_a(1'b1, 16'h1234, 2'b01, 1'b0);
    step();
    step();
    reset = 1'b1;
    drive_a(1'b1, 16'h4321, 2'b01, 1'b1);
    step();
    reset = 1'b0;
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1 ||
        bus_a.out_data !== 32'h0 || bus_a.out_mode !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid: got v=%b r=%b d=%h m=%b expected v=0 r=1 d=00000000 m=00",
               bus_a.out_valid, bus_a.in_ready, bus_a.out_data, bus_a.out_mode);
    end
    drive_a(1'b1, 16'h00F0, 2'b10, 1'b1);
    step();
    checks++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 32'h00F00000) begin
      failures++;
      $display("FAIL reset_first: got v=%b d=%h expected v=1 d=00f00000", bus_a.out_valid, bus_a.out_data);
    end
    drive_a(1'b0, 16'h0, 2'b00, 1'b1);
    step();
    checks++;
    if (bus_a.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_alone: got out_valid=%b expected 0", bus_a.out_valid);
    end
  endtask

  task automatic test_param_sweep();
    logic [7:0]  imms  [4] = '{8'h80, 8'h12, 8'h81, 8'hFF};
    logic [1:0]  modes [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [15:0] exps  [4] = '{16'hFF80, 16'h1200, 16'hFE04, 16'h00FF};
    for (int k = 0; k < 4; k++) begin
      bus_b.in_valid = 1'b1; bus_b.imm = imms[k]; bus_b.mode = modes[k]; bus_b.out_ready = 1'b1;
      step();
      checks++;
      if (bus_b.out_valid !== 1'b1 || bus_b.out_data !== exps[k] || bus_b.out_mode !== modes[k]) begin
        failures++;
        $display("FAIL sweep[%0d]: got v=%b d=%h m=%b expected v=1 d=%h m=%b",
                 k, bus_b.out_valid, bus_b.out_data, bus_b.out_mode, exps[k], modes[k]);
      end
    end
    bus_b.in_valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    item_t       q[$];
    item_t       it;
    int          pv, pr;
    int          n = 10000;
    logic        in_fire, out_fire, stalled;
    logic [31:0] held_d;
    logic [1:0]  held_m;
    int          pv_tab [4] = '{80, 50, 30, 95};
    int          pr_tab [4] = '{80, 30, 50, 95};
    for (int c = 0; c < n + 4; c++) begin
      pv = pv_tab[(c / 2500) % 4];
      pr = pr_tab[(c / 2500) % 4];
      if (c < n)
        drive_a($urandom_range(0, 99) < pv, 16'($urandom), 2'($urandom), $urandom_range(0, 99) < pr);
      else
        drive_a(1'b0, 16'($urandom), 2'b00, 1'b1);
      in_fire  = bus_a.in_valid && bus_a.in_ready;
      out_fire = bus_a.out_valid && bus_a.out_ready;
      stalled  = bus_a.out_valid && !bus_a.out_ready;
      held_d   = bus_a.out_data;
      held_m   = bus_a.out_mode;
      if (out_fire) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rnd_extra[%0d]: got d=%h with nothing pending expected no output", c, bus_a.out_data);
        end else begin
          it = q.pop_front();
          if (bus_a.out_data !== it.d || bus_a.out_mode !== it.m) begin
            failures++;
            $display("FAIL rnd_data[%0d]: got d=%h m=%b expected d=%h m=%b",
                     c, bus_a.out_data, bus_a.out_mode, it.d, it.m);
          end
        end
      end
      if (in_fire) begin
        it.d = 32'(model_f(16, 32, longint'(bus_a.imm), bus_a.mode));
        it.m = bus_a.mode;
        q.push_back(it);
      end
      step();
      checks++;
      if (bus_a.out_valid !== (q.size() != 0) || bus_a.in_ready !== (q.size() < 2)) begin
        failures++;
        $display("FAIL rnd_flags[%0d]: got v=%b r=%b expected v=%b r=%b (pending %0d)",
                 c, bus_a.out_valid, bus_a.in_ready, q.size() != 0, q.size() < 2, q.size());
      end
      if (stalled) begin
        checks++;
        if (bus_a.out_data !== held_d || bus_a.out_mode !== held_m) begin
          failures++;
          $display("FAIL rnd_stable[%0d]: got d=%h m=%b expected d=%h m=%b",
                   c, bus_a.out_data, bus_a.out_mode, held_d, held_m);
        end
      end
    end
    checks++;
    if (q.size() != 0 || bus_a.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rnd_drain: got pending=%0d v=%b expected pending=0 v=0", q.size(), bus_a.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_drain_refill();
    test_reset_mid();
    test_param_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
